// File: rtl/module_ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline register.
// Contents: default datapath/register-address widths, control-bit indices,
// and the stage state encoding.
package module_ex_mem_stage_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_RADDR = 5;
  localparam int unsigned CTL_W     = 4;

  // Bit positions inside ctl = {regwrite, memread, memwrite, memtoreg}
  localparam int unsigned CTL_REGWRITE = 3;
  localparam int unsigned CTL_MEMREAD  = 2;
  localparam int unsigned CTL_MEMWRITE = 1;
  localparam int unsigned CTL_MEMTOREG = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    TRAP  = 2'd2
  } state_t;

endpackage

// File: rtl/module_ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side handshake and payload, MEM-side handshake and
// registered payload, and the overflow-exception signals.
// Modports:
//   master - the surrounding pipeline (drives EX payload, out_ready, flush, exc_ack)
//   slave  - the EX/MEM stage itself
interface module_ex_mem_stage_if #(
  parameter int unsigned WIDTH = module_ex_mem_stage_pkg::DEF_WIDTH,
  parameter int unsigned RADDR = module_ex_mem_stage_pkg::DEF_RADDR
) ();

  // EX side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic             alu_v;
  logic             ovf_check;
  logic [WIDTH-1:0] store_data;
  logic [RADDR-1:0] rd_in;
  logic [WIDTH-1:0] pc_in;
  logic [3:0]       ctl_in;
  logic             flush;

  // MEM side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] store_q;
  logic [RADDR-1:0] rd_q;
  logic [3:0]       ctl_q;

  // Exception
  logic             exc_ovf;
  logic [WIDTH-1:0] epc_q;
  logic             exc_pending;
  logic             exc_ack;

  modport master (
    output in_valid, alu_result, alu_v, ovf_check, store_data, rd_in, pc_in,
           ctl_in, flush, out_ready, exc_ack,
    input  in_ready, out_valid, result_q, zero_q, store_q, rd_q, ctl_q,
           exc_ovf, epc_q, exc_pending
  );

  modport slave (
    input  in_valid, alu_result, alu_v, ovf_check, store_data, rd_in, pc_in,
           ctl_in, flush, out_ready, exc_ack,
    output in_ready, out_valid, result_q, zero_q, store_q, rd_q, ctl_q,
           exc_ovf, epc_q, exc_pending
  );

endinterface

// File: rtl/module_ex_mem_stage_zero.sv
// Zero detect: WIDTH-input NOR reduction of the ALU result bus.
// Ports: data_i (WIDTH) in, zero_o out (combinational, 1 when data_i == 0).
module module_zero_detect #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             zero_o
);

  assign zero_o = ~|data_i;

endmodule

// File: rtl/module_ex_mem_stage.sv
// EX/MEM pipeline register behind the 32-bit ripple ALU.
// Captures ALU result, derived zero flag, store data, destination and control
// on a valid/ready accept; supports stall, drain and flush. With OVF_TRAP_EN
// defined, an accepted signed add/sub whose MSB slice overflowed has its
// regwrite/memwrite squashed, records its PC in epc_q, pulses exc_ovf and
// blocks further accepts until exc_ack.
// Ports: clk, rst_n (synchronous, active-low), bus (module_ex_mem_stage_if.slave).
// Build option: OVF_TRAP_EN.
module module_ex_mem_stage
  import module_ex_mem_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RADDR = DEF_RADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  module_ex_mem_stage_if.slave  bus
);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   store_q, store_d;
  logic [RADDR-1:0]   rd_q, rd_d;
  logic [CTL_W-1:0]   ctl_q, ctl_d;
  logic               exc_ovf_q, exc_ovf_d;
  logic [WIDTH-1:0]   epc_q, epc_d;

  logic alu_zero_c;
  logic ovf_hit_c;
  logic exc_ack_c;
  logic trap_c;
  logic in_ready_c;
  logic accept_c;
  logic drain_c;

  module_zero_detect #(.WIDTH(WIDTH)) u_zero (
    .data_i (bus.alu_result),
    .zero_o (alu_zero_c)
  );

`ifdef OVF_TRAP_EN
  assign ovf_hit_c = bus.ovf_check & bus.alu_v;
  assign exc_ack_c = bus.exc_ack;
  assign trap_c    = (state_q == TRAP);
`else
  // Overflow inputs have no effect in this build.
  logic unused_ok;
  assign unused_ok = ^{bus.ovf_check, bus.alu_v, bus.exc_ack};
  assign ovf_hit_c = 1'b0;
  assign exc_ack_c = 1'b0;
  assign trap_c    = 1'b0;
`endif

  // A pending exception blocks new accepts; otherwise full throughput.
  assign in_ready_c = !trap_c && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c && !bus.flush;
  assign drain_c    = out_valid_q && bus.out_ready;

  // State register and payload registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      store_q     <= '0;
      rd_q        <= '0;
      ctl_q       <= '0;
      exc_ovf_q   <= 1'b0;
      epc_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      ctl_q       <= ctl_d;
      exc_ovf_q   <= exc_ovf_d;
      epc_q       <= epc_d;
    end
  end

  // Next-state and payload update
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    store_d     = store_q;
    rd_d        = rd_q;
    ctl_d       = ctl_q;
    exc_ovf_d   = 1'b0;
    epc_d       = epc_q;

    if (accept_c) begin
      out_valid_d = 1'b1;
      result_d    = bus.alu_result;
      zero_d      = alu_zero_c;
      store_d     = bus.store_data;
      rd_d        = bus.rd_in;
      ctl_d       = bus.ctl_in;
      if (ovf_hit_c) begin
        // Faulting instruction must not update architectural state.
        ctl_d[CTL_REGWRITE] = 1'b0;
        ctl_d[CTL_MEMWRITE] = 1'b0;
        epc_d               = bus.pc_in;
        exc_ovf_d           = 1'b1;
      end
    end else if (drain_c) begin
      out_valid_d = 1'b0;
    end

    // Flush kills both the held entry and any entry arriving this cycle.
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      EMPTY, FULL: state_d = out_valid_d ? FULL : EMPTY;
      TRAP:        if (exc_ack_c) state_d = out_valid_d ? FULL : EMPTY;
      default:     state_d = EMPTY;
    endcase

    if (accept_c && ovf_hit_c) begin
      state_d = TRAP;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.result_q    = result_q;
  assign bus.zero_q      = zero_q;
  assign bus.store_q     = store_q;
  assign bus.rd_q        = rd_q;
  assign bus.ctl_q       = ctl_q;
  assign bus.exc_ovf     = exc_ovf_q;
  assign bus.epc_q       = epc_q;
  assign bus.exc_pending = trap_c;

endmodule

// File: tb/tb_module_ex_mem_stage.sv
// Self-checking bench for module_ex_mem_stage: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_module_ex_mem_stage;

`ifdef OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  module_ex_mem_stage_if #(.WIDTH(32), .RADDR(5)) bus ();

  module_ex_mem_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of what MEM should see
  bit        m_valid;
  bit [31:0] m_res;
  bit        m_zero;
  bit [31:0] m_store;
  bit [4:0]  m_rd;
  bit [3:0]  m_ctl;
  bit        m_exc;
  bit [31:0] m_epc;
  bit        m_pend;

  function automatic bit model_ready();
    if (TRAP_EN) return !m_pend && (!m_valid || bus.out_ready);
    return !m_valid || bus.out_ready;
  endfunction

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.alu_result = '0;
    bus.alu_v      = 1'b0;
    bus.ovf_check  = 1'b0;
    bus.store_data = '0;
    bus.rd_in      = '0;
    bus.pc_in      = '0;
    bus.ctl_in     = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus.exc_ack    = 1'b0;
  endtask

  task automatic drive(input bit [31:0] res, input bit av, input bit oc,
                       input bit [31:0] pc, input bit [3:0] ctl);
    bus.in_valid   = 1'b1;
    bus.alu_result = res;
    bus.alu_v      = av;
    bus.ovf_check  = oc;
    bus.store_data = res ^ 32'hA5A5_0000;
    bus.rd_in      = res[4:0];
    bus.pc_in      = pc;
    bus.ctl_in     = ctl;
  endtask

  // Advance one clock; update the model from the architectural rules.
  task automatic tick();
    bit acc, ovf, drn;
    acc = bus.in_valid && model_ready() && !bus.flush;
    ovf = TRAP_EN && acc && bus.ovf_check && bus.alu_v;
    drn = m_valid && bus.out_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 0; m_res = 0; m_zero = 0; m_store = 0; m_rd = 0;
      m_ctl = 0; m_exc = 0; m_epc = 0; m_pend = 0;
    end else begin
      if (acc) begin
        m_res   = bus.alu_result;
        m_zero  = (bus.alu_result == 32'd0);
        m_store = bus.store_data;
        m_rd    = bus.rd_in;
        m_ctl   = ovf ? (bus.ctl_in & 4'b0101) : bus.ctl_in;
      end
      if (bus.flush)  m_valid = 0;
      else if (acc)   m_valid = 1;
      else if (drn)   m_valid = 0;
      m_exc = ovf;
      if (ovf) begin
        m_epc  = bus.pc_in;
        m_pend = 1;
      end else if (bus.exc_ack) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result_q !== 32'd0 || bus.ctl_q !== 4'd0 ||
        bus.exc_ovf !== 1'b0 || bus.epc_q !== 32'd0 || bus.exc_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out_valid=%b result=%h ctl=%b exc=%b epc=%h pend=%b, required all zero",
               bus.out_valid, bus.result_q, bus.ctl_q, bus.exc_ovf, bus.epc_q, bus.exc_pending);
    end
    n_checks++;
    #1;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_zero_accept();
    idle();
    drive(32'h0, 1'b0, 1'b0, 32'h0040_0000, 4'b1000);
    tick();
    idle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.zero_q !== 1'b1 || bus.ctl_q !== 4'b1000) begin
      n_fail++;
      $display("FAIL zero_accept: valid=%b zero=%b ctl=%b required 1 1 1000",
               bus.out_valid, bus.zero_q, bus.ctl_q);
    end
  endtask

  task automatic test_back_to_back();
    bit [31:0] vals [2];
    vals[0] = 32'h5;
    vals[1] = 32'h7;
    for (int i = 0; i < 2; i++) begin
      drive(vals[i], 1'b0, 1'b0, 32'h0040_0100 + 32'(i * 4), 4'b1000);
      bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready[%0d]: got %b required 1", i, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.result_q !== vals[i] || bus.out_valid !== 1'b1 || bus.zero_q !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got %h valid=%b zero=%b required %h 1 0",
                 i, bus.result_q, bus.out_valid, bus.zero_q, vals[i]);
      end
    end
  endtask

  task automatic test_stall();
    drive(32'h9, 1'b0, 1'b0, 32'h0040_0200, 4'b1100);
    bus.out_ready = 1'b1;
    tick();
    drive(32'hA, 1'b0, 1'b0, 32'h0040_0204, 4'b1000);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_in_ready[%0d]: got %b required 0", i, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.result_q !== 32'h9 || bus.ctl_q !== 4'b1100 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: result=%h ctl=%b valid=%b required 00000009 1100 1",
                 i, bus.result_q, bus.ctl_q, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    idle();
    n_checks++;
    if (bus.result_q !== 32'hA || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: result=%h valid=%b required 0000000a 1",
               bus.result_q, bus.out_valid);
    end
  endtask

  task automatic test_overflow();
    drive(32'h8000_0000, 1'b1, 1'b1, 32'h0040_0010, 4'b1000);
    bus.out_ready = 1'b1;
    tick();
    idle();
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.ctl_q !== m_ctl || bus.exc_ovf !== m_exc || bus.epc_q !== m_epc ||
        bus.exc_pending !== m_pend || bus.result_q !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL ovf_take: ctl=%b exc=%b epc=%h pend=%b res=%h required %b %b %h %b 80000000",
               bus.ctl_q, bus.exc_ovf, bus.epc_q, bus.exc_pending, bus.result_q,
               m_ctl, m_exc, m_epc, m_pend);
    end
    // addu with the same operands offered while a trap may be pending
    drive(32'h8000_0000, 1'b1, 1'b0, 32'h0040_0014, 4'b1000);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL ovf_block[%0d]: in_ready=%b required %b", i, bus.in_ready, model_ready());
      end
      tick();
      n_checks++;
      if (bus.exc_ovf !== m_exc || bus.exc_pending !== m_pend || bus.epc_q !== m_epc) begin
        n_fail++;
        $display("FAIL ovf_pulse[%0d]: exc=%b pend=%b epc=%h required %b %b %h",
                 i, bus.exc_ovf, bus.exc_pending, bus.epc_q, m_exc, m_pend, m_epc);
      end
    end
    bus.in_valid = 1'b0;
    bus.exc_ack  = 1'b1;
    tick();
    bus.exc_ack  = 1'b0;
    n_checks++;
    if (bus.exc_pending !== 1'b0 || bus.epc_q !== m_epc) begin
      n_fail++;
      $display("FAIL ovf_ack: pend=%b epc=%h required 0 %h", bus.exc_pending, bus.epc_q, m_epc);
    end
    drive(32'h8000_0000, 1'b1, 1'b0, 32'h0040_0018, 4'b1000);
    tick();
    idle();
    n_checks++;
    if (bus.ctl_q !== 4'b1000 || bus.exc_ovf !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL addu_no_trap: ctl=%b exc=%b valid=%b required 1000 0 1",
               bus.ctl_q, bus.exc_ovf, bus.out_valid);
    end
  endtask

  task automatic test_flush();
    idle();
    bus.out_ready = 1'b1;
    drive(32'h1234, 1'b0, 1'b0, 32'h0040_0300, 4'b0110);
    tick();
    drive(32'h5678, 1'b0, 1'b0, 32'h0040_0304, 4'b1000);
    bus.flush = 1'b1;
    tick();
    idle();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result_q !== 32'h1234 || bus.ctl_q !== 4'b0110) begin
      n_fail++;
      $display("FAIL flush: valid=%b result=%h ctl=%b required 0 00001234 0110",
               bus.out_valid, bus.result_q, bus.ctl_q);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    drive(32'h7FFF_FFFF, 1'b1, 1'b1, 32'h0040_0400, 4'b1010);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.exc_pending !== 1'b0 || bus.epc_q !== 32'd0 ||
        bus.exc_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b pend=%b epc=%h exc=%b required 0 0 0 0",
               bus.out_valid, bus.exc_pending, bus.epc_q, bus.exc_ovf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.alu_result = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      bus.alu_v      = $urandom_range(0, 1) != 0;
      bus.ovf_check  = ($urandom_range(0, 3) == 0);
      bus.store_data = $urandom;
      bus.rd_in      = 5'($urandom);
      bus.pc_in      = $urandom & 32'hFFFF_FFFC;
      bus.ctl_in     = 4'($urandom);
      bus.flush      = ($urandom_range(0, 15) == 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.exc_ack    = ($urandom_range(0, 7) == 0);
      rst_n          = ($urandom_range(0, 63) != 0);
      #1;
      n_checks++;
      if (bus.in_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL rnd_in_ready[%0d]: got %b required %b", i, bus.in_ready, model_ready());
      end
      tick();
      n_checks++;
      if (bus.out_valid !== m_valid || bus.result_q !== m_res || bus.zero_q !== m_zero ||
          bus.store_q !== m_store || bus.rd_q !== m_rd || bus.ctl_q !== m_ctl ||
          bus.exc_ovf !== m_exc || bus.epc_q !== m_epc || bus.exc_pending !== m_pend) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: v=%b r=%h z=%b s=%h rd=%h c=%b x=%b e=%h p=%b required v=%b r=%h z=%b s=%h rd=%h c=%b x=%b e=%h p=%b",
                 i, bus.out_valid, bus.result_q, bus.zero_q, bus.store_q, bus.rd_q,
                 bus.ctl_q, bus.exc_ovf, bus.epc_q, bus.exc_pending,
                 m_valid, m_res, m_zero, m_store, m_rd, m_ctl, m_exc, m_epc, m_pend);
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    test_reset();
    test_zero_accept();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
